// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: controller states and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_baud_tick_gen.sv
// Bit-rate timer: counts 0..CLK_DIV-1 and flags the terminal count as the end of a serial bit.
module baud_tick_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: single-entry holding register, bit timing and tsr load/shift
// sequencing for start, LSB-first data, optional parity and stop bits.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CLK_DIV    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] tsr_d_in,
  output logic             tsr_ld_sh,
  output logic             tsr_en,
  input  logic             tsr_d_out,
  output logic             txd,
  output logic             busy
);

  localparam int IDX_W = $clog2(WIDTH + 2);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  tx_state_t        state;
  logic             thr_full;
  logic [WIDTH-1:0] thr;
  logic             parity_q;
  logic [IDX_W-1:0] bit_idx;
  logic             tick;
  logic             accept;
  logic             load;
  logic             shift;
  logic             stop_done;

  assign accept    = tx_valid && tx_ready;
  assign stop_done = (state == STOP) && tick && (bit_idx == LAST_STOP);
  // Loading from the last stop cycle lets the next start bit follow with no idle gap.
  assign load      = thr_full && ((state == IDLE) || stop_done);
  assign shift     = (state == DATA) && tick;

  baud_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .tick(tick)
  );

  // tx_ready mirrors !thr_full as its own register so it never rises in the transfer cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_full <= 1'b0;
      tx_ready <= 1'b1;
      thr      <= '0;
    end else if (accept) begin
      thr_full <= 1'b1;
      tx_ready <= 1'b0;
      thr      <= tx_data;
    end else if (load) begin
      thr_full <= 1'b0;
      tx_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_idx  <= '0;
      parity_q <= 1'b0;
    end else if (load) begin
      state    <= START;
      bit_idx  <= '0;
      parity_q <= (^thr) ^ PAR_MODE;
    end else begin
      case (state)
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_DATA) begin
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state   <= STOP;
            bit_idx <= '0;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              state <= IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The tsr already presents data bit 0 after the load, so only data-bit ends shift it.
  always_comb begin
    tsr_en    = load | shift;
    tsr_ld_sh = load;
    tsr_d_in  = thr;
    case (state)
      START:   txd = 1'b0;
      DATA:    txd = tsr_d_out;
      PARITY:  txd = parity_q;
      default: txd = 1'b1;
    endcase
  end

  assign busy = (state != IDLE) | thr_full;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit controller directly upstream of the tsr (transmit shift register) in the UART TX path.
- Accepts parallel words over a valid/ready handshake into a single-entry transmit holding register (THR).
- Generates the bit-rate timing and drives tsr load/shift controls.
- Frames each word onto the serial line: start, WIDTH data bits LSB-first, optional parity, stop.

Parameters:
- WIDTH, 8, data bits per frame; must match the tsr WIDTH.
- CLK_DIV, 16, clk cycles per serial bit (>=2).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  WIDTH  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  THR empty; word accepted on tx_valid & tx_ready.
- tsr_d_in  out  WIDTH  parallel load data to tsr (THR contents).
- tsr_ld_sh  out  1  to tsr: 1 = load, 0 = shift.
- tsr_en  out  1  to tsr: one-cycle enable for load or shift.
- tsr_d_out  in  1  tsr serial output; current data bit, LSB-first.
- txd  out  1  serial line; idles high.
- busy  out  1  frame in progress or THR full.

Behaviour:
Reset:
- state=IDLE, THR empty, bit/baud counters 0.
- txd=1, tx_ready=1, busy=0, tsr_en=0, tsr_ld_sh=0, tsr_d_in=0.
- A reset mid-frame aborts the frame: txd=1 from the next cycle, the pending THR word is discarded, and no further tsr_en pulses occur.

THR handshake:
- tx_ready = !thr_full, registered.
- On accept, thr_full=1 at the next edge.
- tx_ready does not rise in the same cycle as the THR-to-tsr transfer. It reasserts the cycle after.

States and transitions:
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE with thr_full (cycle t):
  - Drive tsr_en=1, tsr_ld_sh=1, tsr_d_in=THR.
  - Latch parity_q = ^THR, inverted if PARITY_ODD.
  - Clear thr_full, clear the baud counter, go to START at the edge.
  - First start-bit cycle is t+1.
- Baud counter runs 0..CLK_DIV-1. A bit ends on the cycle where the count equals CLK_DIV-1.
- START end: go to DATA, bit_idx=0. No tsr pulse; bit0 is already on tsr_d_out.
- DATA bit end: tsr_en=1, tsr_ld_sh=0 (shift).
  - bit_idx < WIDTH-1: increment bit_idx.
  - Otherwise: go to PARITY if PARITY_EN, else STOP.
- PARITY end: go to STOP.
- STOP: lasts STOP_BITS*CLK_DIV cycles.
  - At its end, if thr_full, perform the IDLE load action and go directly to START. This gives gap-free back-to-back frames.
  - Otherwise go to IDLE.

Outputs:
- tsr_en is never asserted outside the load cycle and the data-bit-end cycles.
- txd is selected by the registered state:
  - IDLE/STOP: 1.
  - START: 0.
  - DATA: tsr_d_out.
  - PARITY: parity_q.
- busy = (state!=IDLE) | thr_full.
- Frame length = (1+WIDTH+PARITY_EN+STOP_BITS)*CLK_DIV cycles.
- tx_valid held while tx_ready=0 stalls the upstream. The word is neither lost nor duplicated.

Decomposition:
- Shared package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
  - Parity mode constants PAR_EVEN=0, PAR_ODD=1.
- One sub-module: baud_tick_gen.
  - Parameter CLK_DIV.
  - Ports: clk, rst, clr, tick.
  - Counts 0..CLK_DIV-1 and pulses tick on the terminal count.
  - clr restarts the count at 0.

Test Plan:
All scenarios use CLK_DIV=4, WIDTH=8, with a tsr instance connected to tsr_* ports.
- Reset: hold rst 2 cycles -> txd=1, tx_ready=1, busy=0, tsr_en=0 throughout.
- Send 0xA5, no parity, 1 stop -> one load pulse with tsr_d_in=0xA5 and 8 shift pulses 4 cycles apart. txd bits 0,1,0,1,0,0,1,0,1,1 at 4 cycles each, 40 cycles total, then busy=0.
- PARITY_EN=1: 0x07 even -> parity bit 1; 0x07 odd -> parity bit 0. Frame is 44 cycles.
- Back-to-back: write 0x55, then 0xAA during the first frame's data bits -> start of 0xAA immediately follows the last stop cycle with zero idle cycles. tx_ready=0 from the 0xAA accept until its transfer cycle+1.
- Third word 0x3C held valid while THR full -> tx_ready=0, word accepted only after 0xAA loads. Serial output is 0x55, 0xAA, 0x3C exactly once each.
- Reset asserted during data bit 3 of 0xF0 -> txd=1 next cycle, state IDLE, THR empty, no further tsr_en pulses. A new 0x81 sent afterwards transmits correctly.
- STOP_BITS=2 -> stop high for 8 cycles, frame 44 cycles.
